klt_roi_scheduler: RTL
======================

Name: klt_roi_scheduler

Overview:
- Time-multiplexes the single KLT gradient integrator among NUM_FEAT tracked features, one feature per frame pass, in round-robin order.
- Generates the integrator's in_roi/roi_end from the streamed pixel coordinates and captures G11/G12/G22/b1/b2 when the integrator reports data_valid.
- Presents the captured sums to the downstream 2x2 solver over a valid/ready handshake.
- Sits between the line-buffer/context generator and the integrator + solver.

Parameters:
- NUM_FEAT, 2, number of feature slots (power of 2, >=2)
- WIN, 10, ROI side length in pixels (even)
- COORD_W, 10, width of pixel coordinates
- IMG_W, 640, image width in pixels
- IMG_H, 480, image height in pixels

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- feat_load  in  1  write feature slot
- feat_idx  in  log2(NUM_FEAT)  slot index for feat_load
- feat_x  in  COORD_W  feature centre column
- feat_y  in  COORD_W  feature centre row
- feat_en  in  1  slot active bit written with feat_load
- pix_x  in  COORD_W  column of current context pixel
- pix_y  in  COORD_W  row of current context pixel
- context_valid  in  1  pix_x/pix_y valid this cycle
- first_frame  in  1  frame has no predecessor
- end_of_frame  in  1  one-cycle pulse; integrator clears on it
- in_roi  out  1  to integrator
- roi_end  out  1  to integrator, one-cycle pulse
- int_data_valid  in  1  integrator data_valid
- G11, G12, G22, b1, b2  in  26 each  integrator sums
- res_valid  out  1  result available
- res_ready  in  1  solver accepts
- res_idx  out  log2(NUM_FEAT)  feature slot of result
- res_G11, res_G12, res_G22, res_b1, res_b2  out  26 each  captured sums
- overrun  out  1  sticky: result lost or frame skipped

Behaviour:
- Reset: all outputs 0, FSM=IDLE, all slots inactive with coords 0, rr pointer 0, overrun 0. Reset mid-operation aborts any window or pending result with no output.
- Slot table: feat_load writes {x, y, en} to feat_idx in the next cycle. Bounds are latched at arming, so a load to the armed slot affects only later arming.
- Window for centre (fx, fy): columns fx-WIN/2 .. fx+WIN/2-1, rows fy-WIN/2 .. fy+WIN/2-1.
- A slot is eligible if en=1 and the window lies fully inside 0..IMG_W-1 x 0..IMG_H-1. Ineligible slots are skipped silently.
- FSM IDLE, on end_of_frame: pick the first eligible slot starting at the rr pointer (wrapping).
  - If one is found: latch its bounds, go to ARMED, rr pointer = chosen+1 mod NUM_FEAT.
  - Otherwise stay in IDLE.
- ARMED:
  - in_roi = combinational compare of pix_x/pix_y against the latched bounds, ANDed with context_valid. Zero latency, same cycle as the pixel.
  - roi_end = 1 for one cycle when context_valid and pix equals the bottom-right corner.
  - Then go to WAIT if first_frame=0, else IDLE (no result).
  - If end_of_frame arrives before the corner: set overrun, re-arm per the IDLE rule.
- WAIT: in_roi=0. On the first cycle int_data_valid=1, latch the five sums and res_idx, set res_valid, go to OUT.
  - If end_of_frame comes first: set overrun, go to IDLE and apply the IDLE arming rule in the same cycle.
  - int_data_valid in any other state is ignored.
- OUT: res_* held stable while res_valid && !res_ready. Transfer happens on res_valid && res_ready; res_valid drops next cycle, go to IDLE.
- end_of_frame during OUT:
  - That frame gets no arming; set overrun, stay in OUT.
  - If the transfer and end_of_frame happen in the same cycle, the transfer wins, the state goes to IDLE, and the arming for that end_of_frame proceeds (no overrun).
- Pass-through: sums are copied unmodified; G21 is not output (equals G12).

Test Plan:
- IMG 64x48, WIN 10, slot0=(20,15) en, raster scan, first_frame=0 -> in_roi high exactly for x 15..24, y 10..19 (100 pixels); roi_end pulses once at (24,19).
- Same frame, int_data_valid asserted 3 cycles after roi_end with G11=0x123, b2=0x3FFFFFF, res_ready=1 -> res_valid one cycle, res_idx=0, res_G11=0x123, res_b2=0x3FFFFFF.
- Slots 0 and 1 enabled, four frames -> res_idx sequence 0,1,0,1; slot1=(3,15) (out of bounds) -> sequence 0,0,0,0 with overrun=0.
- res_ready held 0 across the next end_of_frame -> outputs stable, overrun=1, no in_roi in that frame; release res_ready -> single transfer.
- first_frame=1 during an armed frame -> roi_end pulses, no res_valid; end_of_frame before int_data_valid -> overrun=1.
- rst asserted while in WAIT -> next cycle all outputs 0; int_data_valid afterwards produces no result.

Source files
------------

// File: rtl/klt_roi_scheduler.sv
// Round-robin ROI scheduler for a single shared KLT gradient integrator.
// Arms one feature window per frame, captures the integrator sums and hands them to the solver.
module klt_roi_scheduler #(
    parameter int NUM_FEAT = 2,
    parameter int WIN      = 10,
    parameter int COORD_W  = 10,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        feat_load,
    input  logic [$clog2(NUM_FEAT)-1:0] feat_idx,
    input  logic [COORD_W-1:0]          feat_x,
    input  logic [COORD_W-1:0]          feat_y,
    input  logic                        feat_en,
    input  logic [COORD_W-1:0]          pix_x,
    input  logic [COORD_W-1:0]          pix_y,
    input  logic                        context_valid,
    input  logic                        first_frame,
    input  logic                        end_of_frame,
    output logic                        in_roi,
    output logic                        roi_end,
    input  logic                        int_data_valid,
    input  logic [25:0]                 G11,
    input  logic [25:0]                 G12,
    input  logic [25:0]                 G22,
    input  logic [25:0]                 b1,
    input  logic [25:0]                 b2,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [$clog2(NUM_FEAT)-1:0] res_idx,
    output logic [25:0]                 res_G11,
    output logic [25:0]                 res_G12,
    output logic [25:0]                 res_G22,
    output logic [25:0]                 res_b1,
    output logic [25:0]                 res_b2,
    output logic                        overrun
);
    // state | meaning
    // IDLE  | no window armed, waiting for end_of_frame to pick a slot
    // ARMED | window bounds latched, flagging pixels until the bottom-right corner
    // WAIT  | window closed, waiting for the integrator's data_valid
    // OUT   | sums held for the solver until res_ready
    localparam int IDX_W = $clog2(NUM_FEAT);
    localparam int HALF  = WIN / 2;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WAIT, S_OUT} state_t;

    state_t state, state_nxt;

    logic [COORD_W-1:0] slot_x [NUM_FEAT];
    logic [COORD_W-1:0] slot_y [NUM_FEAT];
    logic [NUM_FEAT-1:0] slot_en;
    logic [NUM_FEAT-1:0] elig;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   cur_idx;
    logic               arm_found;
    logic [IDX_W-1:0]   arm_idx;

    logic [COORD_W-1:0] x_lo, x_hi, y_lo, y_hi;
    logic               at_corner;
    logic               do_arm, do_capture, set_ovr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FEAT; i++) begin
                slot_x[i] <= '0;
                slot_y[i] <= '0;
            end
            slot_en <= '0;
        end else if (feat_load) begin
            slot_x[feat_idx]  <= feat_x;
            slot_y[feat_idx]  <= feat_y;
            slot_en[feat_idx] <= feat_en;
        end
    end

    // A slot is usable only if its whole window lies inside the image.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_FEAT; i++) begin
            elig[i] = slot_en[i]
                      && (int'(slot_x[i]) >= HALF) && (int'(slot_x[i]) + HALF <= IMG_W)
                      && (int'(slot_y[i]) >= HALF) && (int'(slot_y[i]) + HALF <= IMG_H);
        end
    end

    // Walk backwards so the candidate closest to rr_ptr is the one that sticks.
    always_comb begin
        arm_found = 1'b0;
        arm_idx   = rr_ptr;
        for (int k = NUM_FEAT - 1; k >= 0; k--) begin
            if (elig[rr_ptr + IDX_W'(k)]) begin
                arm_found = 1'b1;
                arm_idx   = rr_ptr + IDX_W'(k);
            end
        end
    end

    assign at_corner = context_valid && (pix_x == x_hi) && (pix_y == y_hi);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        do_arm     = 1'b0;
        do_capture = 1'b0;
        set_ovr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (end_of_frame && arm_found) begin
                    do_arm    = 1'b1;
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (at_corner) begin
                    state_nxt = first_frame ? S_IDLE : S_WAIT;
                end else if (end_of_frame) begin
                    set_ovr   = 1'b1;
                    do_arm    = arm_found;
                    state_nxt = arm_found ? S_ARMED : S_IDLE;
                end
            end
            S_WAIT: begin
                if (int_data_valid) begin
                    do_capture = 1'b1;
                    state_nxt  = S_OUT;
                end else if (end_of_frame) begin
                    set_ovr   = 1'b1;
                    do_arm    = arm_found;
                    state_nxt = arm_found ? S_ARMED : S_IDLE;
                end
            end
            S_OUT: begin
                // A transfer coinciding with end_of_frame frees the integrator in time for that frame.
                if (res_ready) begin
                    do_arm    = end_of_frame && arm_found;
                    state_nxt = (end_of_frame && arm_found) ? S_ARMED : S_IDLE;
                end else if (end_of_frame) begin
                    set_ovr = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_roi    = 1'b0;
        roi_end   = 1'b0;
        res_valid = 1'b0;
        case (state)
            S_ARMED: begin
                in_roi  = context_valid && (pix_x >= x_lo) && (pix_x <= x_hi)
                          && (pix_y >= y_lo) && (pix_y <= y_hi);
                roi_end = at_corner;
            end
            S_OUT:   res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_lo    <= '0;
            x_hi    <= '0;
            y_lo    <= '0;
            y_hi    <= '0;
            cur_idx <= '0;
            rr_ptr  <= '0;
            overrun <= 1'b0;
            res_idx <= '0;
            res_G11 <= '0;
            res_G12 <= '0;
            res_G22 <= '0;
            res_b1  <= '0;
            res_b2  <= '0;
        end else begin
            if (do_arm) begin
                x_lo    <= slot_x[arm_idx] - COORD_W'(HALF);
                x_hi    <= slot_x[arm_idx] + COORD_W'(HALF - 1);
                y_lo    <= slot_y[arm_idx] - COORD_W'(HALF);
                y_hi    <= slot_y[arm_idx] + COORD_W'(HALF - 1);
                cur_idx <= arm_idx;
                rr_ptr  <= arm_idx + IDX_W'(1);
            end
            if (do_capture) begin
                res_idx <= cur_idx;
                res_G11 <= G11;
                res_G12 <= G12;
                res_G22 <= G22;
                res_b1  <= b1;
                res_b2  <= b2;
            end
            if (set_ovr) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
